// File: rtl/updn_counter_pkg.sv
// Shared types and mode encodings for the parametrised up/down counter.
package updn_counter_pkg;

  typedef enum logic [1:0] {
    CNT_HOLD,
    CNT_LOAD,
    CNT_UP,
    CNT_DOWN
  } cnt_op_e;

  typedef enum logic {
    EVT_OVF,
    EVT_UDF
  } evt_kind_e;

  localparam logic MODE_WRAP = 1'b0;
  localparam logic MODE_SAT  = 1'b1;

endpackage

// File: rtl/updn_step_unit.sv
// Combinational next-count calculation for one enabled count step.
// Purely combinational; the caller registers the results.
module updn_step_unit
  import updn_counter_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] cur,
  input  logic [WIDTH-1:0] s,
  input  logic [WIDTH-1:0] limit,
  input  logic             up,
  input  logic             sat,
  output logic [WIDTH-1:0] nxt,
  output logic             evt,
  output evt_kind_e        kind
);

  localparam logic [WIDTH:0] ONE = (WIDTH+1)'(1);

  logic [WIDTH:0]   cur_x, s_x, lim_x, sum;
  logic [WIDTH-1:0] sum_lo, diff_lo, wrap_up, wrap_dn;

  // One extra bit so cur+s and cur+limit+1 never truncate before comparison.
  assign cur_x   = {1'b0, cur};
  assign s_x     = {1'b0, s};
  assign lim_x   = {1'b0, limit};
  assign sum     = cur_x + s_x;
  assign sum_lo  = WIDTH'(sum);
  assign diff_lo = WIDTH'(cur_x - s_x);
  assign wrap_up = WIDTH'(sum - lim_x - ONE);
  assign wrap_dn = WIDTH'(cur_x + lim_x + ONE - s_x);

  always_comb begin
    nxt  = cur;
    evt  = 1'b0;
    kind = EVT_OVF;
    if (s_x != '0) begin
      if (cur_x > lim_x) begin
        nxt = '0;
        evt = 1'b1;
      end else if (up) begin
        if (sum <= lim_x) begin
          nxt = sum_lo;
        end else begin
          evt = 1'b1;
          nxt = (sat == MODE_SAT) ? limit : wrap_up;
        end
      end else begin
        if (s_x <= cur_x) begin
          nxt = diff_lo;
        end else begin
          evt  = 1'b1;
          kind = EVT_UDF;
          nxt  = (sat == MODE_SAT) ? '0 : wrap_dn;
        end
      end
    end
  end

endmodule

// File: rtl/updn_counter_param.sv
// Loadable WIDTH-bit up/down counter, range 0..limit, wrap or saturate, with tc pulse and sticky flags.
// One clock from inputs to all outputs; always accepts inputs (no backpressure).
module updn_counter_param
  import updn_counter_pkg::*;
#(
  parameter int WIDTH    = 16,
  parameter int SATURATE = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ld_cnt,
  input  logic [WIDTH-1:0] data_in,
  input  logic             count_enb,
  input  logic             updn_cnt,
  input  logic [WIDTH-1:0] step,
  input  logic [WIDTH-1:0] limit,
  input  logic             clr_flags,
  output logic [WIDTH-1:0] data_out,
  output logic             tc,
  output logic             ovf,
  output logic             udf
);

  localparam logic SAT_MODE = (SATURATE != 0) ? MODE_SAT : MODE_WRAP;

  cnt_op_e          op;
  logic [WIDTH-1:0] s, ld_val, nxt;
  logic             evt, cnt_evt;
  evt_kind_e        kind;

  always_comb begin
    op = CNT_HOLD;
    if (!ld_cnt)       op = CNT_LOAD;
    else if (count_enb) op = updn_cnt ? CNT_UP : CNT_DOWN;
  end

  assign s      = (step < limit) ? step : limit;
  assign ld_val = (data_in < limit) ? data_in : limit;

  updn_step_unit #(.WIDTH(WIDTH)) u_step (
    .cur   (data_out),
    .s     (s),
    .limit (limit),
    .up    (op == CNT_UP),
    .sat   (SAT_MODE),
    .nxt   (nxt),
    .evt   (evt),
    .kind  (kind)
  );

  assign cnt_evt = evt && (op == CNT_UP || op == CNT_DOWN);

  always_ff @(posedge clk) begin
    if (rst) begin
      data_out <= '0;
      tc       <= 1'b0;
      ovf      <= 1'b0;
      udf      <= 1'b0;
    end else begin
      tc  <= cnt_evt;
      // A flag raised this cycle wins over a simultaneous clear.
      ovf <= (cnt_evt && kind == EVT_OVF) || (ovf && !clr_flags);
      udf <= (cnt_evt && kind == EVT_UDF) || (udf && !clr_flags);
      case (op)
        CNT_LOAD: data_out <= ld_val;
        CNT_UP,
        CNT_DOWN: data_out <= nxt;
        CNT_HOLD: data_out <= data_out;
        default:  data_out <= data_out;
      endcase
    end
  end

endmodule

// File: tb/tb_updn_counter_param.sv
// Directed checks of wrap (w_*) and saturate (s_*) counters driven by identical inputs.
module tb_updn_counter_param;

  logic       clk = 1'b0;
  logic       rst, ld_cnt, count_enb, updn_cnt, clr_flags;
  logic [7:0] data_in, step, limit;
  logic [7:0] w_data, s_data;
  logic       w_tc, w_ovf, w_udf, s_tc, s_ovf, s_udf;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  updn_counter_param #(.WIDTH(8), .SATURATE(0)) dut_wrap (
    .clk(clk), .rst(rst), .ld_cnt(ld_cnt), .data_in(data_in),
    .count_enb(count_enb), .updn_cnt(updn_cnt), .step(step), .limit(limit),
    .clr_flags(clr_flags), .data_out(w_data), .tc(w_tc), .ovf(w_ovf), .udf(w_udf)
  );

  updn_counter_param #(.WIDTH(8), .SATURATE(1)) dut_sat (
    .clk(clk), .rst(rst), .ld_cnt(ld_cnt), .data_in(data_in),
    .count_enb(count_enb), .updn_cnt(updn_cnt), .step(step), .limit(limit),
    .clr_flags(clr_flags), .data_out(s_data), .tc(s_tc), .ovf(s_ovf), .udf(s_udf)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_w(input string tag, input int d, input int t, input int o, input int u);
    chk({tag, " w_data"}, 32'(w_data), d);
    chk({tag, " w_tc"},   32'(w_tc),   t);
    chk({tag, " w_ovf"},  32'(w_ovf),  o);
    chk({tag, " w_udf"},  32'(w_udf),  u);
  endtask

  task automatic chk_s(input string tag, input int d, input int t, input int o, input int u);
    chk({tag, " s_data"}, 32'(s_data), d);
    chk({tag, " s_tc"},   32'(s_tc),   t);
    chk({tag, " s_ovf"},  32'(s_ovf),  o);
    chk({tag, " s_udf"},  32'(s_udf),  u);
  endtask

  initial begin
    rst = 1'b1; ld_cnt = 1'b1; count_enb = 1'b0; updn_cnt = 1'b1;
    clr_flags = 1'b0; data_in = 8'd0; step = 8'd3; limit = 8'd9;
    tick();
    chk_w("reset", 0, 0, 0, 0);
    chk_s("reset", 0, 0, 0, 0);

    // Up-count across limit=9 from 8 with step 3.
    rst = 1'b0; ld_cnt = 1'b0; data_in = 8'd8;
    tick();
    chk_w("load8", 8, 0, 0, 0);
    chk_s("load8", 8, 0, 0, 0);
    ld_cnt = 1'b1; count_enb = 1'b1; updn_cnt = 1'b1;
    tick();
    chk_w("up1", 1, 1, 1, 0);
    chk_s("up1", 9, 1, 1, 0);
    tick();
    chk_w("up2", 4, 0, 1, 0);
    chk_s("up2", 9, 1, 1, 0);
    count_enb = 1'b0;
    tick();
    chk_w("hold", 4, 0, 1, 0);
    chk_s("hold", 9, 0, 1, 0);

    // Down-count below zero, flags cleared during the load.
    ld_cnt = 1'b0; data_in = 8'd1; clr_flags = 1'b1;
    tick();
    chk_w("load1", 1, 0, 0, 0);
    chk_s("load1", 1, 0, 0, 0);
    ld_cnt = 1'b1; clr_flags = 1'b0; count_enb = 1'b1; updn_cnt = 1'b0;
    tick();
    chk_w("down", 8, 1, 0, 1);
    chk_s("down", 0, 1, 0, 1);
    count_enb = 1'b0; clr_flags = 1'b1;
    tick();
    chk_w("clr", 8, 0, 0, 0);
    chk_s("clr", 0, 0, 0, 0);
    clr_flags = 1'b0;

    // Load above limit clamps, then idles.
    ld_cnt = 1'b0; data_in = 8'd200;
    tick();
    chk_w("load200", 9, 0, 0, 0);
    chk_s("load200", 9, 0, 0, 0);
    ld_cnt = 1'b1; count_enb = 1'b0; updn_cnt = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("idle w_data", 32'(w_data), 9);
      chk("idle w_tc", 32'(w_tc), 0);
      chk("idle s_data", 32'(s_data), 9);
    end

    // Reset mid-count beats a simultaneous load.
    ld_cnt = 1'b0; data_in = 8'd5; step = 8'd1;
    tick();
    ld_cnt = 1'b1; count_enb = 1'b1;
    tick();
    tick();
    chk_w("run7", 7, 0, 0, 0);
    chk_s("run7", 7, 0, 0, 0);
    rst = 1'b1; ld_cnt = 1'b0; data_in = 8'd3;
    tick();
    chk_w("rst_mid", 0, 0, 0, 0);
    chk_s("rst_mid", 0, 0, 0, 0);
    rst = 1'b0; ld_cnt = 1'b1; count_enb = 1'b0;

    // Lowering limit below the current count.
    ld_cnt = 1'b0; data_in = 8'd8;
    tick();
    ld_cnt = 1'b1; limit = 8'd5; count_enb = 1'b1; updn_cnt = 1'b1; step = 8'd1;
    tick();
    chk_w("oor", 0, 1, 1, 0);
    chk_s("oor", 0, 1, 1, 0);
    step = 8'd5;
    tick();
    chk_w("to5", 5, 0, 1, 0);
    chk_s("to5", 5, 0, 1, 0);
    clr_flags = 1'b1;
    tick();
    chk_w("clr_vs_evt", 4, 1, 1, 0);
    chk_s("clr_vs_evt", 5, 1, 1, 0);
    count_enb = 1'b0;
    tick();
    chk_w("clr2", 4, 0, 0, 0);
    chk_s("clr2", 5, 0, 0, 0);
    clr_flags = 1'b0;

    // limit=0 pins the count at zero with no events.
    limit = 8'd0; ld_cnt = 1'b0; data_in = 8'd7;
    tick();
    ld_cnt = 1'b1; count_enb = 1'b1; step = 8'd3;
    tick();
    chk_w("lim0", 0, 0, 0, 0);
    chk_s("lim0", 0, 0, 0, 0);

    // Reset clears flags that were set.
    limit = 8'd9; ld_cnt = 1'b0; data_in = 8'd9; count_enb = 1'b0;
    tick();
    ld_cnt = 1'b1; count_enb = 1'b1; step = 8'd1;
    tick();
    chk_w("pre_rst", 0, 1, 1, 0);
    chk_s("pre_rst", 9, 1, 1, 0);
    rst = 1'b1;
    tick();
    chk_w("rst_flags", 0, 0, 0, 0);
    chk_s("rst_flags", 0, 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
